// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link: default frame geometry and the
// receiver FSM state encoding.
package spi_pkg;

    localparam int BW_DATA  = 16;
    localparam int BW_COUNT = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_SHIFT    = 2'd1;
    localparam state_t ST_COMPLETE = 2'd2;
    localparam state_t ST_WAIT_CS  = 2'd3;

endpackage

// File: rtl/spi_receiver_if.sv
// Pin-level SPI inputs plus the parallel Valid/Ack word interface of the
// receiver, grouped so the bench and the LM8 side can share one bundle.
interface spi_receiver_if #(parameter int BW_DATA = spi_pkg::BW_DATA);
    import spi_pkg::*;

    logic               SClock;
    logic               MOSI;
    logic               nCS;
    logic               Ack;
    logic [BW_DATA-1:0] Data;
    logic               Valid;
    logic               Overrun;
    logic               FrameError;

    modport slave (
        input  SClock, MOSI, nCS, Ack,
        output Data, Valid, Overrun, FrameError
    );

    modport master (
        output SClock, MOSI, nCS, Ack,
        input  Data, Valid, Overrun, FrameError
    );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous pin, with an optional history
// flop that turns the synchronised level into single-cycle edge strobes.
module spi_sync #(
    parameter logic RST_VAL  = 1'b0,
    parameter bit   EDGE_DET = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign level = sync_q;

    generate
        if (EDGE_DET) begin : g_edge
            logic hist_q, hist_d;

            always_comb hist_d = sync_q;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) hist_q <= RST_VAL;
                else       hist_q <= hist_d;
            end

            assign rise = sync_q & ~hist_q;
            assign fall = ~sync_q & hist_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_receiver.sv
// Write-only SPI slave: deserialises MSB-first frames into a parallel word
// handed to the LM8 side through a Valid/Ack handshake.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int bw_data  = BW_DATA,
    parameter int bw_count = BW_COUNT
) (
    input  logic           Clock,
    input  logic           Reset,
    spi_receiver_if.slave  bus
);

    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;

    // nCS chain resets low so a frame already running at release is not a start.
    spi_sync #(.RST_VAL(1'b0), .EDGE_DET(1'b1)) u_sync_sck (
        .Clock(Clock), .Reset(Reset), .pin(bus.SClock),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.RST_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_mosi (
        .Clock(Clock), .Reset(Reset), .pin(bus.MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync #(.RST_VAL(1'b0), .EDGE_DET(1'b1)) u_sync_cs (
        .Clock(Clock), .Reset(Reset), .pin(bus.nCS),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sck_level, sck_fall, mosi_rise, mosi_fall};

    state_t              state_q, state_d;
    logic [bw_count-1:0] count_q, count_d;
    logic [bw_data-1:0]  sr_q, sr_d;
    logic [bw_data-1:0]  data_q, data_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                fe_q, fe_d;
    logic                err_seen_q, err_seen_d;

    localparam logic [bw_count-1:0] LAST_IDX = bw_count'(bw_data - 1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cs_rise)                            state_d = ST_IDLE;
                else if (sck_rise && count_q == LAST_IDX) state_d = ST_COMPLETE;
            end
            // A very short tail could raise nCS during COMPLETE; don't miss it.
            ST_COMPLETE: state_d = cs_rise ? ST_IDLE : ST_WAIT_CS;
            ST_WAIT_CS:  if (cs_rise) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        sr_d       = sr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        fe_d       = 1'b0;
        err_seen_d = err_seen_q;

        if (bus.Ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                count_d    = '0;
                err_seen_d = 1'b0;
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    fe_d    = 1'b1;
                    count_d = '0;
                    sr_d    = '0;
                end else if (sck_rise) begin
                    sr_d    = (sr_q << 1) | bw_data'(mosi_level);
                    count_d = count_q + 1'b1;
                end
            end
            ST_COMPLETE: begin
                // An Ack landing in this cycle frees the register for the new word.
                if (!valid_q || bus.Ack) begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            ST_WAIT_CS: begin
                if (sck_rise && !cs_level && !err_seen_q) begin
                    fe_d       = 1'b1;
                    err_seen_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q    <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            fe_q       <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            fe_q       <= fe_d;
            err_seen_q <= err_seen_d;
        end
    end

    assign bus.Data       = data_q;
    assign bus.Valid      = valid_q;
    assign bus.Overrun    = overrun_q;
    assign bus.FrameError = fe_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: a Clock/32 SPI master model drives directed and
// random frames; a word-level model predicts Data/Valid/Overrun/FrameError.
module tb_spi_receiver;
    import spi_pkg::*;

    logic Clock;
    logic Reset;

    spi_receiver_if #(.BW_DATA(16)) bus ();

    spi_receiver #(.bw_data(16), .bw_count(5)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_overrun;
    int          exp_fe;

    int fe_pulses  = 0;
    int valid_drop = 0;
    bit mon_valid  = 0;

    always @(posedge Clock) begin
        if (bus.FrameError) fe_pulses++;
        if (mon_valid && !bus.Valid) valid_drop++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".data"},    32'(bus.Data),    32'(exp_data));
        check_eq({tag, ".valid"},   32'(bus.Valid),   32'(exp_valid));
        check_eq({tag, ".overrun"}, 32'(bus.Overrun), 32'(exp_overrun));
        check_eq({tag, ".fe"},      32'(fe_pulses),   32'(exp_fe));
    endtask

    function automatic logic frame_bit(input logic [15:0] w, input int i);
        if (i < 16) return w[15 - i];
        return 1'b1;
    endfunction

    // Word-level model of a frame that completed with nbits SClock rises.
    task automatic model_frame(input logic [15:0] w, input int nbits, input bit ack_same);
        if (nbits < 16) begin
            exp_fe++;
        end else begin
            if (!exp_valid || ack_same) begin
                exp_data    = w;
                exp_valid   = 1'b1;
                exp_overrun = 1'b0;
            end else begin
                exp_overrun = 1'b1;
            end
            if (nbits > 16) exp_fe++;
        end
    endtask

    // mode 0: plain; 1: Ack pulse in the cycle after the last rise is shifted;
    // 2: measure Valid latency after the last rise.
    task automatic send_bits(input logic [15:0] w, input int first, input int last, input int mode);
        int lat;
        for (int i = first; i <= last; i++) begin
            bus.MOSI = frame_bit(w, i);
            tick(16);
            bus.SClock = 1'b1;
            if (i == last && mode == 1) begin
                tick(3);
                bus.Ack = 1'b1;
                tick(1);
                bus.Ack = 1'b0;
                tick(12);
            end else if (i == last && mode == 2) begin
                lat = -1;
                for (int c = 1; c <= 6; c++) begin
                    tick(1);
                    if (bus.Valid && lat < 0) lat = c;
                end
                check_eq("valid_latency_in_1_to_5", 32'(lat >= 1 && lat <= 5), 32'd1);
                tick(10);
            end else begin
                tick(16);
            end
            bus.SClock = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int nbits, input int mode);
        bus.nCS = 1'b0;
        send_bits(w, 0, nbits - 1, mode);
        tick(16);
        bus.nCS = 1'b1;
        tick(8);
        model_frame(w, nbits, mode == 1);
    endtask

    task automatic do_ack();
        bus.Ack = 1'b1;
        tick(1);
        bus.Ack = 1'b0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    task automatic model_reset();
        exp_data    = '0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        int nb;
        int mode;

        Reset      = 1'b1;
        bus.SClock = 1'b0;
        bus.MOSI   = 1'b0;
        bus.nCS    = 1'b1;
        bus.Ack    = 1'b0;
        model_reset();
        exp_fe = 0;
        tick(4);
        Reset = 1'b0;
        tick(6);
        check_state("reset");

        // Single frame, Ack 10 cycles later.
        send_frame(16'hA5C3, 16, 2);
        check_state("a5c3");
        tick(10);
        do_ack();
        check_eq("a5c3.valid_after_ack", 32'(bus.Valid), 32'd0);

        // Two frames without Ack: second one is dropped.
        send_frame(16'h1234, 16, 0);
        send_frame(16'hFFFF, 16, 0);
        check_state("overrun");
        do_ack();
        check_state("overrun_ack");

        // Ack coinciding with delivery of 0x8001 while 0x1234 is pending.
        send_frame(16'h1234, 16, 0);
        mon_valid = 1'b1;
        send_frame(16'h8001, 16, 1);
        mon_valid = 1'b0;
        check_state("ack_in_complete");
        check_eq("ack_in_complete.valid_drops", 32'(valid_drop), 32'd0);
        do_ack();

        // Short frame then a good one.
        send_frame(16'h5555, 7, 0);
        check_state("short7");
        send_frame(16'h00FF, 16, 0);
        check_state("after_short");
        do_ack();

        // One extra rise inside the nCS window.
        send_frame(16'hBEEF, 17, 0);
        check_state("extra_rise");
        do_ack();

        // Reset in the middle of a frame with nCS still low at release.
        bus.nCS = 1'b0;
        send_bits(16'hC3C3, 0, 8, 0);
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        model_reset();
        check_state("mid_reset");
        send_bits(16'hC3C3, 9, 15, 0);
        tick(16);
        bus.nCS = 1'b1;
        tick(8);
        check_state("mid_reset_tail");
        send_frame(16'h5A5A, 16, 0);
        check_state("after_reset");
        do_ack();

        // Random frames, lengths and Ack placement.
        for (int k = 0; k < 20; k++) begin
            w  = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 16;
            mode = (nb == 16 && $urandom_range(0, 3) == 0) ? 1 : 0;
            send_frame(w, nb, mode);
            check_state($sformatf("rand%0d", k));
            if ($urandom_range(0, 2) == 0) do_ack();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_receiver.md
# spi_receiver

Write-only SPI slave that deserialises frames produced by the team's SPI master (MSB first, MOSI changes on SClock falling edge, nCS low for exactly `bw_data` SClock periods). It synchronises the three SPI pins into the `Clock` domain, samples MOSI on SClock rising edges, and presents each completed word on a parallel register with a Valid/Ack handshake toward the LM8 side. It sits in loopback/test paths and on any board-level link where this design is the SPI target.

## Interface
- `bw_data`, 16: frame width in bits (1..31).
- `bw_count`, 5: bit-counter width; must satisfy 2^`bw_count` > `bw_data`.
- `Clock`  in  1: system clock; one clock, all logic on rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `SClock`  in  1: SPI clock, asynchronous to `Clock`; period ≥ 8 `Clock` cycles, high and low phases ≥ 4 cycles each.
- `MOSI`  in  1: serial data, MSB first.
- `nCS`  in  1: active-low frame select.
- `Data`  out  `bw_data`: last completed word; held until overwritten.
- `Valid`  out  1: level; high while `Data` holds an unacknowledged word.
- `Ack`  in  1: one-cycle pulse; clears `Valid` and `Overrun`.
- `Overrun`  out  1: sticky; a word completed while `Valid` was high and was dropped.
- `FrameError`  out  1: one-cycle pulse on a malformed frame.

## Operation
- Synchronisers: 2 flops per pin, plus 1 history flop on SClock and nCS for edge detection. Reset values: SClock chain 0, MOSI chain 0, nCS chain **0**. A frame already in progress at reset release is therefore not seen as a start.
- `rise` = synced SClock 0→1. `csfall` / `csrise` = synced nCS edges.
- FSM states:
  - IDLE: count=0. `csfall` → SHIFT.
  - SHIFT: on each `rise`, shift register ← {sr[bw_data-2:0], MOSI_sync} and count+1.
    - When count reaches `bw_data`, go to COMPLETE.
    - `csrise` with count < `bw_data` → FrameError pulse, partial word discarded → IDLE.
  - COMPLETE: one cycle; deliver the word (rules below) → WAIT_CS.
  - WAIT_CS: `rise` with nCS still low → one FrameError pulse (only the first such edge per frame); no data is captured. `csrise` → IDLE.
- Delivery rules in COMPLETE:
  - Valid=0, or Ack in the same cycle → `Data` ← sr, Valid=1.
  - Valid=1 and no Ack → word dropped, `Data` unchanged, Overrun=1.
- Ack with Valid=0 has no effect. Ack clears Overrun in every case.
- `csfall` in any state other than IDLE is impossible by construction; `csrise` in IDLE is ignored.
- Reset mid-frame: all state is cleared immediately, the partial word is lost, and the block returns to IDLE.
- Reset values: `Data`=0, `Valid`=0, `Overrun`=0, `FrameError`=0, state=IDLE, count=0, sr=0.

## Timing
- Pin-to-detect latency: 3 `Clock` edges from an SClock/nCS pin transition to `rise`/`csfall`/`csrise`.
- MOSI is captured from the same sync stage as SClock. With ≥ 4-cycle half periods, MOSI is stable at capture.
- Valid rises 2 cycles after the cycle in which the `bw_data`-th `rise` is detected (shift cycle, then COMPLETE). That is at most 5 `Clock` cycles after the final SClock pin rising edge.
- Minimum inter-frame gap: nCS high for ≥ 4 `Clock` cycles.
- Frame period with the master at Clock/32 SClock: Valid updates at most once per ~`bw_data`×32 cycles. Ack latency is free within that window.

## Structure
- Package `spi_pkg`: FSM state encoding (IDLE, SHIFT, COMPLETE, WAIT_CS as 2-bit localparams) and the default `bw_data`/`bw_count`, shared with the transmitter.
- Sub-module `spi_sync`: 2-flop synchroniser plus history flop, parameterised reset value, outputs level/rise/fall. Instantiated once each for SClock, MOSI and nCS.
- Top level holds the FSM, counter, shift register and output register.

## Test plan
- Single frame 0xA5C3 from a Clock/32 master model, Ack 10 cycles after Valid → Data=0xA5C3; Valid high ≤ 5 cycles after the last SClock rise, then low 1 cycle after Ack; FrameError and Overrun stay 0.
- Two back-to-back frames 0x1234, 0xFFFF with no Ack → Data=0x1234, Overrun=1 after the second frame. Ack → Valid=0, Overrun=0.
- Ack asserted exactly in the COMPLETE cycle of frame 0x8001 while 0x1234 is pending → Data=0x8001, Valid stays 1, Overrun=0.
- nCS raised after 7 bits → one FrameError pulse, Valid unchanged. Next full frame 0x00FF → Data=0x00FF.
- 17 SClock rises inside one nCS window, frame 0xBEEF → Data=0xBEEF, exactly one FrameError pulse.
- Reset pulsed at bit 9 of a frame, nCS still low at release, remaining bits clocked → no Valid, no FrameError. Following frame 0x5A5A → Data=0x5A5A.
